// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: multi-stage pipeline register with stall/bubble/flush, valid tracking and a pass-through lane
module pipe_stage_reg #(
    parameter int                CTRL_W              = 2,
    parameter int                DATA_W              = 69,
    parameter int                PASS_W              = 32,
    parameter int                STAGES              = 1,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE         = '0,
    parameter int                ZERO_DATA_ON_BUBBLE = 1,
    localparam int               OCC_W               = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              bubble,
    input  logic              flush,
    input  logic              i_valid,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    input  logic [PASS_W-1:0] i_pass,
    output logic              o_valid,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data,
    output logic [PASS_W-1:0] o_pass,
    output logic [OCC_W-1:0]  o_occupancy,
    output logic [15:0]       o_bubble_cnt
);
    if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
        $error("pipe_stage_reg: STAGES must be within 1..8");
    end
    localparam bit ZDB = ZERO_DATA_ON_BUBBLE != 0;
    logic [STAGES-1:0] valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q [STAGES];
    logic [CTRL_W-1:0] ctrl_d [STAGES];
    logic [DATA_W-1:0] data_q [STAGES];
    logic [DATA_W-1:0] data_d [STAGES];
    logic [15:0]       bcnt_q, bcnt_d;
    logic [OCC_W-1:0]  occ;
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        bcnt_d  = bcnt_q;
        if (flush) begin
            valid_d = '0;
            for (int i = 0; i < STAGES; i++) begin
                ctrl_d[i] = CTRL_BUBBLE;
                data_d[i] = ZDB ? '0 : data_q[i];
            end
        end else if (!stall) begin
            for (int i = 1; i < STAGES; i++) begin
                valid_d[i] = valid_q[i-1];
                ctrl_d[i]  = ctrl_q[i-1];
                data_d[i]  = data_q[i-1];
            end
            // invalid entries always carry the bubble control so no write enable leaks downstream
            valid_d[0] = !bubble && i_valid;
            ctrl_d[0]  = (!bubble && i_valid) ? i_ctrl : CTRL_BUBBLE;
            data_d[0]  = !bubble ? i_data : (ZDB ? '0 : data_q[0]);
            bcnt_d     = bcnt_q + 16'(bubble && bcnt_q != 16'hFFFF);
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            bcnt_q  <= '0;
            for (int i = 0; i < STAGES; i++) begin
                ctrl_q[i] <= CTRL_BUBBLE;
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
            bcnt_q  <= bcnt_d;
        end
    end
    always_comb begin
        occ = '0;
        for (int i = 0; i < STAGES; i++) occ = occ + OCC_W'(valid_q[i]);
    end
    assign o_valid      = valid_q[STAGES-1];
    assign o_ctrl       = ctrl_q[STAGES-1];
    assign o_data       = data_q[STAGES-1];
    assign o_pass       = i_pass;
    assign o_occupancy  = occ;
    assign o_bubble_cnt = bcnt_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed table, hand sequences and random stimulus against a queue-based model
module tb_pipe_stage_reg;
    typedef struct packed {logic v; logic [1:0] c; logic [68:0] d;} ent_t;
    typedef struct packed {
        logic r, f, s, b, v; logic [1:0] c; logic [68:0] d; logic [31:0] p;
        logic ev; logic [1:0] ec; logic [68:0] ed; logic [1:0] eo; logic [15:0] eb;
    } vec_t;
    logic clk = 1'b0, rst = 1'b0, flush = 1'b0, stall = 1'b0, bubble = 1'b0, i_valid = 1'b0;
    logic [1:0] i_ctrl = '0;
    logic [68:0] i_data = '0;
    logic [31:0] i_pass = '0;
    logic v3, v2;
    logic [1:0] c3, c2, o3, o2;
    logic [68:0] d3, d2;
    logic [31:0] p3, p2;
    logic [15:0] b3, b2;
    int checks = 0, errors = 0, bcnt = 0;
    ent_t q3[$], q2[$];
    vec_t tbl[17];

    pipe_stage_reg #(.STAGES(3)) u3 (
        .clk(clk), .rst(rst), .stall(stall), .bubble(bubble), .flush(flush),
        .i_valid(i_valid), .i_ctrl(i_ctrl), .i_data(i_data), .i_pass(i_pass),
        .o_valid(v3), .o_ctrl(c3), .o_data(d3), .o_pass(p3), .o_occupancy(o3), .o_bubble_cnt(b3));
    pipe_stage_reg #(.STAGES(2), .ZERO_DATA_ON_BUBBLE(0), .CTRL_BUBBLE(2'b01)) u2 (
        .clk(clk), .rst(rst), .stall(stall), .bubble(bubble), .flush(flush),
        .i_valid(i_valid), .i_ctrl(i_ctrl), .i_data(i_data), .i_pass(i_pass),
        .o_valid(v2), .o_ctrl(c2), .o_data(d2), .o_pass(p2), .o_occupancy(o2), .o_bubble_cnt(b2));

    always #5 clk = ~clk;

    function automatic void chk(string n, logic [68:0] a, logic [68:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endfunction

    // q[0] is the newest entry, q[$] the one presented on the outputs
    function automatic void adv(ref ent_t q[$], input bit zdb, input logic [1:0] cb);
        ent_t n;
        if (rst) begin
            foreach (q[i]) q[i] = {1'b0, cb, 69'd0};
        end else if (flush) begin
            foreach (q[i]) begin
                q[i].v = 1'b0;
                q[i].c = cb;
                if (zdb) q[i].d = '0;
            end
        end else if (!stall) begin
            n = bubble ? {1'b0, cb, zdb ? 69'd0 : q[0].d} : {i_valid, i_valid ? i_ctrl : cb, i_data};
            void'(q.pop_back());
            q.push_front(n);
        end
    endfunction

    task automatic tick();
        int n3, n2;
        adv(q3, 1'b1, 2'b00);
        adv(q2, 1'b0, 2'b01);
        if (rst) bcnt = 0;
        else if (!flush && !stall && bubble) bcnt++;
        @(posedge clk);
        #1;
        n3 = 0;
        n2 = 0;
        foreach (q3[i]) n3 += int'(q3[i].v);
        foreach (q2[i]) n2 += int'(q2[i].v);
        chk("u3 valid", 69'(v3), 69'(q3[2].v));
        chk("u3 ctrl", 69'(c3), 69'(q3[2].c));
        chk("u3 data", d3, q3[2].d);
        chk("u3 occ", 69'(o3), 69'(n3));
        chk("u3 bcnt", 69'(b3), 69'(bcnt > 65535 ? 65535 : bcnt));
        chk("u3 pass", 69'(p3), 69'(i_pass));
        chk("u2 valid", 69'(v2), 69'(q2[1].v));
        chk("u2 ctrl", 69'(c2), 69'(q2[1].c));
        chk("u2 data", d2, q2[1].d);
        chk("u2 occ", 69'(o2), 69'(n2));
        chk("u2 bcnt", 69'(b2), 69'(bcnt > 65535 ? 65535 : bcnt));
        chk("u2 pass", 69'(p2), 69'(i_pass));
    endtask

    task automatic drive(logic r, logic f, logic s, logic b, logic v, logic [1:0] c, logic [68:0] d);
        rst = r; flush = f; stall = s; bubble = b; i_valid = v; i_ctrl = c; i_data = d;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) q3.push_back('0);
        for (int i = 0; i < 2; i++) q2.push_back('0);
        //            r f s b v c  d   p             ev ec ed  eo eb
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 0,  32'h100,       0, 0, 0,  0, 0};
        tbl[1]  = '{0, 0, 0, 0, 1, 3, 11, 32'h101,       0, 0, 0,  1, 0};
        tbl[2]  = '{0, 0, 0, 0, 1, 3, 12, 32'h102,       0, 0, 0,  2, 0};
        tbl[3]  = '{0, 0, 0, 0, 1, 3, 13, 32'h103,       1, 3, 11, 3, 0};
        tbl[4]  = '{1, 0, 0, 0, 1, 3, 14, 32'h104,       0, 0, 0,  0, 0};
        tbl[5]  = '{0, 0, 0, 0, 1, 1, 1,  32'h105,       0, 0, 0,  1, 0};
        tbl[6]  = '{0, 0, 0, 0, 1, 2, 2,  32'h106,       0, 0, 0,  2, 0};
        tbl[7]  = '{0, 0, 0, 0, 1, 1, 3,  32'h107,       1, 1, 1,  3, 0};
        tbl[8]  = '{0, 0, 0, 0, 1, 2, 4,  32'h108,       1, 2, 2,  3, 0};
        tbl[9]  = '{0, 0, 0, 0, 0, 3, 5,  32'h109,       1, 1, 3,  2, 0};
        tbl[10] = '{0, 0, 0, 0, 1, 1, 6,  32'h10A,       1, 2, 4,  2, 0};
        tbl[11] = '{0, 0, 0, 0, 1, 1, 7,  32'h10B,       0, 0, 5,  2, 0};
        tbl[12] = '{0, 0, 0, 0, 1, 3, 8,  32'h10C,       1, 1, 6,  3, 0};
        tbl[13] = '{0, 1, 1, 0, 1, 3, 9,  32'h10D,       0, 0, 0,  0, 0};
        tbl[14] = '{0, 0, 0, 1, 1, 3, 10, 32'h10E,       0, 0, 0,  0, 1};
        tbl[15] = '{0, 0, 1, 1, 0, 0, 0,  32'hDEADBEEF,  0, 0, 0,  0, 1};
        tbl[16] = '{0, 0, 0, 0, 1, 2, 20, 32'h110,       0, 0, 0,  1, 1};
        @(posedge clk);
        #1;
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].r, tbl[i].f, tbl[i].s, tbl[i].b, tbl[i].v, tbl[i].c, tbl[i].d);
            i_pass = tbl[i].p;
            #1;
            chk($sformatf("row%0d pass comb", i), 69'(p3), 69'(tbl[i].p));
            tick();
            chk($sformatf("row%0d valid", i), 69'(v3), 69'(tbl[i].ev));
            chk($sformatf("row%0d ctrl", i), 69'(c3), 69'(tbl[i].ec));
            chk($sformatf("row%0d data", i), d3, tbl[i].ed);
            chk($sformatf("row%0d occ", i), 69'(o3), 69'(tbl[i].eo));
            chk($sformatf("row%0d bcnt", i), 69'(b3), 69'(tbl[i].eb));
        end
        // stall beats bubble on the two-stage instance: B at the output, A behind it
        drive(1, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 1, 2, 69'hB); tick();
        drive(0, 0, 0, 0, 1, 3, 69'hA); tick();
        chk("sb full data", d2, 69'hB);
        drive(0, 0, 1, 1, 1, 1, 69'h77);
        repeat (2) tick();
        chk("sb stalled data", d2, 69'hB);
        chk("sb stalled valid", 69'(v2), 69'd1);
        chk("sb stalled bcnt", 69'(b2), 69'd0);
        drive(0, 0, 0, 1, 1, 1, 69'h77); tick();
        chk("sb released data", d2, 69'hA);
        chk("sb released occ", 69'(o2), 69'd1);
        chk("sb released bcnt", 69'(b2), 69'd1);
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(63) == 0, $urandom_range(15) == 0, $urandom_range(3) == 0,
                  $urandom_range(4) == 0, 1'($urandom), 2'($urandom),
                  69'({$urandom(), $urandom(), $urandom()}));
            i_pass = $urandom();
            tick();
        end
        drive(1, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 1, 1, 3, 69'h5);
        repeat (65537) tick();
        chk("sat bcnt", 69'(b3), 69'hFFFF);
        tick();
        chk("sat hold", 69'(b3), 69'hFFFF);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
